// File: rtl/bsg_vanilla_pkg.sv
// Shared types for the vanilla core data-memory arbiter.
package bsg_vanilla_pkg;

    typedef enum logic {
        LOCAL_PRI    = 1'b0,
        REMOTE_FORCE = 1'b1
    } dmem_arb_state_e;

    localparam int unsigned dmem_arb_starve_ctr_max_lp = 255;

endpackage

// File: rtl/bsg_counter_clear_up.sv
// Up counter with synchronous clear; clear and up together restart at init_val_p + 1.
module bsg_counter_clear_up #(
    parameter int unsigned max_val_p  = 255,
    parameter int unsigned init_val_p = 0,
    localparam int unsigned ptr_width_lp = $clog2(max_val_p + 1)
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    clear_i,
    input  logic                    up_i,
    output logic [ptr_width_lp-1:0] count_o
);

    logic [ptr_width_lp-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = ptr_width_lp'(init_val_p) + ptr_width_lp'(up_i);
        end else begin
            count_d = count_q + ptr_width_lp'(up_i);
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            count_q <= ptr_width_lp'(init_val_p);
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/vanilla_dmem_arbiter.sv
// Local-priority DMEM arbiter with remote anti-starvation forcing.
// Optional conflict statistic enabled by VANILLA_DMEM_ARB_STATS_EN.
module vanilla_dmem_arbiter
    import bsg_vanilla_pkg::*;
#(
    parameter data_width_p      = "inv",
    parameter dmem_addr_width_p = "inv",
    parameter starve_limit_p    = 8,
    localparam mask_width_lp    = data_width_p >> 3
) (
    input  logic                         clk_i,
    input  logic                         reset_i,

    input  logic                         local_v_i,
    input  logic                         local_w_i,
    input  logic [dmem_addr_width_p-1:0] local_addr_i,
    input  logic [data_width_p-1:0]      local_data_i,
    input  logic [mask_width_lp-1:0]     local_mask_i,
    output logic                         local_stall_o,
    output logic [data_width_p-1:0]      local_data_o,
    output logic                         local_data_v_o,

    input  logic                         remote_v_i,
    input  logic                         remote_w_i,
    input  logic [dmem_addr_width_p-1:0] remote_addr_i,
    input  logic [data_width_p-1:0]      remote_data_i,
    input  logic [mask_width_lp-1:0]     remote_mask_i,
    output logic                         remote_yumi_o,
    output logic [data_width_p-1:0]      remote_data_o,
    output logic                         remote_data_v_o,

    output logic                         mem_v_o,
    output logic                         mem_w_o,
    output logic [dmem_addr_width_p-1:0] mem_addr_o,
    output logic [data_width_p-1:0]      mem_data_o,
    output logic [mask_width_lp-1:0]     mem_mask_o,
    input  logic [data_width_p-1:0]      mem_data_i,

    output logic [31:0]                  conflict_count_o
);

    dmem_arb_state_e state_q, state_d;
    logic            local_gnt, remote_gnt;
    logic            ctr_clear, ctr_up;
    logic [7:0]      starve_cnt, starve_cnt_next;
    logic            rd_local_q, rd_local_d;
    logic            rd_remote_q, rd_remote_d;

    bsg_counter_clear_up #(
        .max_val_p (dmem_arb_starve_ctr_max_lp),
        .init_val_p(0)
    ) starve_ctr (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .clear_i(ctr_clear),
        .up_i   (ctr_up),
        .count_o(starve_cnt)
    );

    always_comb begin
        local_gnt       = local_v_i & (state_q == LOCAL_PRI);
        remote_gnt      = remote_v_i & ((state_q == REMOTE_FORCE) | ~local_v_i);
        local_stall_o   = local_v_i & (state_q == REMOTE_FORCE);
        remote_yumi_o   = remote_gnt;

        mem_v_o         = local_gnt | remote_gnt;
        mem_w_o         = remote_gnt ? remote_w_i    : local_w_i;
        mem_addr_o      = remote_gnt ? remote_addr_i : local_addr_i;
        mem_data_o      = remote_gnt ? remote_data_i : local_data_i;
        mem_mask_o      = remote_gnt ? remote_mask_i : local_mask_i;

        // Counter tracks the next value so forcing takes effect the cycle after the limit is hit.
        ctr_clear       = remote_gnt | ~remote_v_i;
        ctr_up          = remote_v_i & ~remote_gnt;
        starve_cnt_next = ctr_clear ? '0 : starve_cnt + 8'(ctr_up);

        state_d = state_q;
        case (state_q)
            LOCAL_PRI:    if (starve_cnt_next == 8'(starve_limit_p)) state_d = REMOTE_FORCE;
            REMOTE_FORCE: if (remote_gnt | ~remote_v_i)              state_d = LOCAL_PRI;
            default:      state_d = LOCAL_PRI;
        endcase

        rd_local_d  = local_gnt  & ~local_w_i;
        rd_remote_d = remote_gnt & ~remote_w_i;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= LOCAL_PRI;
            rd_local_q  <= 1'b0;
            rd_remote_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_local_q  <= rd_local_d;
            rd_remote_q <= rd_remote_d;
        end
    end

    assign local_data_v_o  = rd_local_q;
    assign local_data_o    = mem_data_i;
    assign remote_data_v_o = rd_remote_q;
    assign remote_data_o   = mem_data_i;

`ifdef VANILLA_DMEM_ARB_STATS_EN
    logic [31:0] conflict_q, conflict_d;

    always_comb begin
        conflict_d = conflict_q;
        if (local_v_i & remote_v_i & ~(&conflict_q)) begin
            conflict_d = conflict_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            conflict_q <= '0;
        end else begin
            conflict_q <= conflict_d;
        end
    end

    assign conflict_count_o = conflict_q;
`else
    assign conflict_count_o = '0;
`endif

endmodule

// File: tb/tb_vanilla_dmem_arbiter.sv
// Randomized self-checking bench for vanilla_dmem_arbiter against a behavioural arbitration model.
module tb_vanilla_dmem_arbiter;

    localparam int DW    = 32;
    localparam int AW    = 8;
    localparam int MW    = DW / 8;
    localparam int LIMIT = 4;

    logic          clk = 1'b0;
    logic          reset_i = 1'b1;
    logic          local_v_i = 1'b0, local_w_i = 1'b0;
    logic [AW-1:0] local_addr_i = '0;
    logic [DW-1:0] local_data_i = '0;
    logic [MW-1:0] local_mask_i = '0;
    logic          local_stall_o, local_data_v_o;
    logic [DW-1:0] local_data_o;
    logic          remote_v_i = 1'b0, remote_w_i = 1'b0;
    logic [AW-1:0] remote_addr_i = '0;
    logic [DW-1:0] remote_data_i = '0;
    logic [MW-1:0] remote_mask_i = '0;
    logic          remote_yumi_o, remote_data_v_o;
    logic [DW-1:0] remote_data_o;
    logic          mem_v_o, mem_w_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_data_o;
    logic [MW-1:0] mem_mask_o;
    logic [DW-1:0] mem_data_i;
    logic [31:0]   conflict_count_o;

    always #5 clk = ~clk;

    vanilla_dmem_arbiter #(
        .data_width_p     (DW),
        .dmem_addr_width_p(AW),
        .starve_limit_p   (LIMIT)
    ) dut (
        .clk_i           (clk),
        .reset_i         (reset_i),
        .local_v_i       (local_v_i),
        .local_w_i       (local_w_i),
        .local_addr_i    (local_addr_i),
        .local_data_i    (local_data_i),
        .local_mask_i    (local_mask_i),
        .local_stall_o   (local_stall_o),
        .local_data_o    (local_data_o),
        .local_data_v_o  (local_data_v_o),
        .remote_v_i      (remote_v_i),
        .remote_w_i      (remote_w_i),
        .remote_addr_i   (remote_addr_i),
        .remote_data_i   (remote_data_i),
        .remote_mask_i   (remote_mask_i),
        .remote_yumi_o   (remote_yumi_o),
        .remote_data_o   (remote_data_o),
        .remote_data_v_o (remote_data_v_o),
        .mem_v_o         (mem_v_o),
        .mem_w_o         (mem_w_o),
        .mem_addr_o      (mem_addr_o),
        .mem_data_o      (mem_data_o),
        .mem_mask_o      (mem_mask_o),
        .mem_data_i      (mem_data_i),
        .conflict_count_o(conflict_count_o)
    );

    function automatic logic [DW-1:0] seed_word(input int unsigned i);
        return (32'h9E37_79B9 * i) ^ 32'h1234_5678;
    endfunction

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_w, input logic [DW-1:0] new_w,
                                            input logic [MW-1:0] m);
        logic [DW-1:0] r;
        r = old_w;
        for (int b = 0; b < MW; b++) if (m[b]) r[8*b +: 8] = new_w[8*b +: 8];
        return r;
    endfunction

    // Single-port synchronous DMEM seen by the arbiter.
    logic [DW-1:0] ram [256];
    initial begin
        for (int i = 0; i < 256; i++) ram[i] = seed_word(i);
        mem_data_i = '0;
        forever begin
            @(posedge clk);
            if (mem_v_o) begin
                if (mem_w_o) ram[mem_addr_o] = merge(ram[mem_addr_o], mem_data_o, mem_mask_o);
                else         mem_data_i <= ram[mem_addr_o];
            end
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: arbitration rules, starvation streak, expected returns, memory image.
    logic [DW-1:0] exp_mem [256];
    int            streak;
    bit            forced;
    bit            exp_lval, exp_rval;
    logic [DW-1:0] exp_ldata, exp_rdata;
    longint        conf;

    function automatic logic [31:0] exp_conf();
`ifdef VANILLA_DMEM_ARB_STATS_EN
        return 32'(conf);
`else
        return 32'd0;
`endif
    endfunction

    task automatic model_reset();
        streak = 0; forced = 0; exp_lval = 0; exp_rval = 0; conf = 0;
    endtask

    task automatic cyc(input bit lv, input bit lw, input logic [AW-1:0] la, input logic [DW-1:0] ld,
                       input logic [MW-1:0] lm, input bit rv, input bit rw, input logic [AW-1:0] ra,
                       input logic [DW-1:0] rd, input logic [MW-1:0] rm);
        bit lg, rg;
        @(negedge clk);
        local_v_i = lv;  local_w_i = lw;  local_addr_i = la;  local_data_i = ld;  local_mask_i = rm == rm ? lm : lm;
        remote_v_i = rv; remote_w_i = rw; remote_addr_i = ra; remote_data_i = rd; remote_mask_i = rm;
        #2;
        lg = lv && !forced;
        rg = rv && (forced || !lv);
        check_eq("local_stall", local_stall_o, lv && forced);
        check_eq("remote_yumi", remote_yumi_o, rg);
        check_eq("mem_v", mem_v_o, lg || rg);
        if (lg || rg) begin
            check_eq("mem_w", mem_w_o, rg ? rw : lw);
            check_eq("mem_addr", mem_addr_o, rg ? ra : la);
            check_eq("mem_mask", mem_mask_o, rg ? rm : lm);
            if (rg ? rw : lw) check_eq("mem_data", mem_data_o, rg ? rd : ld);
        end
        check_eq("local_data_v", local_data_v_o, exp_lval);
        check_eq("remote_data_v", remote_data_v_o, exp_rval);
        if (exp_lval) check_eq("local_data", local_data_o, exp_ldata);
        if (exp_rval) check_eq("remote_data", remote_data_o, exp_rdata);
        check_eq("conflict_count", conflict_count_o, exp_conf());

        exp_lval = lg && !lw;
        exp_rval = rg && !rw;
        if (exp_lval) exp_ldata = exp_mem[la];
        if (exp_rval) exp_rdata = exp_mem[ra];
        if (lg && lw) exp_mem[la] = merge(exp_mem[la], ld, lm);
        if (rg && rw) exp_mem[ra] = merge(exp_mem[ra], rd, rm);
        if (lv && rv && conf < 64'hFFFF_FFFF) conf++;
        if (rv && !rg) begin
            streak++;
            if (streak == LIMIT) forced = 1;
        end else begin
            streak = 0;
            forced = 0;
        end
    endtask

    task automatic hit_reset();
        reset_i = 1'b1;
        #1;
        check_eq("rst_local_data_v", local_data_v_o, 0);
        check_eq("rst_remote_data_v", remote_data_v_o, 0);
        check_eq("rst_conflict", conflict_count_o, 0);
        check_eq("rst_local_stall", local_stall_o, 0);
        check_eq("rst_remote_yumi", remote_yumi_o, remote_v_i && !local_v_i);
        model_reset();
        @(negedge clk);
        local_v_i = 1'b0; local_w_i = 1'b0; remote_v_i = 1'b0; remote_w_i = 1'b0;
        reset_i = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) exp_mem[i] = seed_word(i);
        model_reset();
        repeat (2) @(negedge clk);
        hit_reset();

        // Local read of 0x10 alone, then its return.
        cyc(1, 0, 8'h10, '0, 4'hF, 0, 0, '0, '0, '0);
        check_eq("l_read_addr", mem_addr_o, 32'h10);
        cyc(0, 0, '0, '0, '0, 0, 0, '0, '0, '0);

        // Continuous contention: remote forced through on cycle LIMIT+1 only.
        for (int i = 1; i <= 2 * (LIMIT + 1); i++) begin
            cyc(1, 0, 8'(i), '0, 4'hF, 1, 0, 8'(i + 32), '0, 4'hF);
            check_eq("starve_yumi", remote_yumi_o, (i % (LIMIT + 1)) == 0);
            check_eq("starve_stall", local_stall_o, (i % (LIMIT + 1)) == 0);
        end
        cyc(0, 0, '0, '0, '0, 0, 0, '0, '0, '0);

        // Remote partial write while local idle, then read it back.
        cyc(0, 0, '0, '0, '0, 1, 1, 8'h05, 32'hDEAD_BEEF, 4'b0011);
        check_eq("rw_yumi", remote_yumi_o, 1);
        check_eq("rw_mask", mem_mask_o, 32'b0011);
        cyc(0, 0, '0, '0, '0, 1, 0, 8'h05, '0, '0);
        cyc(0, 0, '0, '0, '0, 0, 0, '0, '0, '0);

        // Alternating single-requester reads, back to back.
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) cyc(1, 0, 8'(i), '0, '0, 0, 0, '0, '0, '0);
            else            cyc(0, 0, '0, '0, '0, 1, 0, 8'(i + 64), '0, '0);
        end
        cyc(0, 0, '0, '0, '0, 0, 0, '0, '0, '0);

        // Reset while REMOTE_FORCE with a local read returning.
        hit_reset();
        for (int i = 1; i <= LIMIT + 1; i++) cyc(1, 0, 8'(i), '0, '0, 1, 0, 8'(i + 8), '0, '0);
        check_eq("pre_rst_force_stall", local_stall_o, 1);
        hit_reset();
        cyc(0, 0, '0, '0, '0, 0, 0, '0, '0, '0);

        // Ten conflict cycles from a fresh reset.
        hit_reset();
        for (int i = 0; i < 10; i++) cyc(1, 0, 8'(i), '0, '0, 1, 0, 8'(i), '0, '0);
        cyc(0, 0, '0, '0, '0, 0, 0, '0, '0, '0);
`ifdef VANILLA_DMEM_ARB_STATS_EN
        check_eq("conflict10", conflict_count_o, 32'd10);
`else
        check_eq("conflict10", conflict_count_o, 32'd0);
`endif

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            cyc($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, 8'($urandom_range(0, 31)),
                $urandom, 4'($urandom), $urandom_range(0, 4) < 3, $urandom_range(0, 2) == 0,
                8'($urandom_range(0, 31)), $urandom, 4'($urandom));
        end
        cyc(0, 0, '0, '0, '0, 0, 0, '0, '0, '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vanilla_dmem_arbiter.md
VANILLA_DMEM_ARBITER -- requirements
Module: vanilla_dmem_arbiter

Interface
REQ-001 The module SHALL have parameter data_width_p, default "inv": DMEM word width in bits.
REQ-002 The module SHALL have parameter dmem_addr_width_p, default "inv": DMEM word-address width.
REQ-003 The module SHALL have parameter starve_limit_p, default 8: maximum consecutive denied remote cycles, legal range 1..255.
REQ-004 The module SHALL have port clk_i, input, 1 bit: the single clock.
REQ-005 The module SHALL have port reset_i, input, 1 bit: reset, asynchronous and active-high.
REQ-006 The module SHALL have ports local_v_i / local_w_i, input, 1 bit each: core access request and write enable.
REQ-007 The module SHALL have ports local_addr_i, local_data_i and local_mask_i, input, dmem_addr_width_p / data_width_p / data_width_p>>3 bits: core address, write data and byte mask.
REQ-008 The module SHALL have port local_stall_o, output, 1 bit: core access not granted this cycle.
REQ-009 The module SHALL have ports local_data_o / local_data_v_o, output, data_width_p / 1 bits: core read data and its valid.
REQ-010 The module SHALL have ports remote_v_i / remote_w_i, input, 1 bit each: network access request and write enable.
REQ-011 The module SHALL have ports remote_addr_i, remote_data_i and remote_mask_i, input, widths as for the local port: network address, write data and mask.
REQ-012 The module SHALL have port remote_yumi_o, output, 1 bit: remote request granted and consumed.
REQ-013 The module SHALL have ports remote_data_o / remote_data_v_o, output, data_width_p / 1 bits: remote read data and its valid.
REQ-014 The module SHALL have ports mem_v_o, mem_w_o, mem_addr_o, mem_data_o and mem_mask_o, output: the single-port DMEM command.
REQ-015 The module SHALL have port mem_data_i, input, data_width_p bits: DMEM read data, valid one cycle after a read command.
REQ-016 The module SHALL have port conflict_count_o, output, 32 bits: the conflict statistic (see Configuration).

Function
REQ-017 The arbiter SHALL be a 2-state FSM: LOCAL_PRI (reset state) and REMOTE_FORCE.
REQ-018 In LOCAL_PRI, a local request SHALL win over a remote request; a remote request SHALL be granted only when local_v_i is 0.
REQ-019 In REMOTE_FORCE, a pending remote request SHALL win and local_stall_o SHALL equal local_v_i.
REQ-020 In LOCAL_PRI, local_stall_o SHALL be 0.
REQ-021 Grants SHALL be combinational in the same cycle; mem_v_o SHALL be 1 whenever either requester is granted, and mem_* SHALL mux the winner's fields.
REQ-022 The 8-bit starvation counter SHALL increment in each cycle with remote_v_i=1 and remote_yumi_o=0; it SHALL clear on remote_yumi_o=1, and also in any cycle with remote_v_i=0.
REQ-023 The FSM SHALL move LOCAL_PRI->REMOTE_FORCE when the counter's next value equals starve_limit_p; REMOTE_FORCE->LOCAL_PRI SHALL occur on remote_yumi_o, or when remote_v_i drops.
REQ-024 For a read grant, the winner identity SHALL be registered and the read data returned next cycle: local_data_v_o=1 with local_data_o=mem_data_i, or remote_data_v_o=1 with remote_data_o=mem_data_i.
REQ-025 Writes SHALL produce no data-valid pulse.
REQ-026 Back-to-back reads from alternating winners SHALL sustain one access per cycle with no bubble.

Reset
REQ-027 Asserting reset_i at any time, including mid-operation, SHALL force state LOCAL_PRI, counter 0, both data valids 0 and conflict_count_o 0.
REQ-028 After reset, a read granted before reset SHALL NOT return a valid.
REQ-029 All combinational outputs SHALL follow the request inputs with the reset state.

Configuration
REQ-030 The macro SHALL be VANILLA_DMEM_ARB_STATS_EN.
REQ-031 When VANILLA_DMEM_ARB_STATS_EN is defined, conflict_count_o SHALL be a 32-bit register, incremented by 1 saturating at 0xFFFF_FFFF in each cycle where local_v_i and remote_v_i are both 1.
REQ-032 When VANILLA_DMEM_ARB_STATS_EN is undefined, conflict_count_o SHALL be tied to 0, the port SHALL remain present and no counter flops SHALL be synthesized.

Structure
REQ-033 The enum dmem_arb_state_e {LOCAL_PRI, REMOTE_FORCE} SHALL reside in bsg_vanilla_pkg.
REQ-034 The starvation counter SHALL be one bsg_counter_clear_up instance; there SHALL be no other sub-modules.

Verification
REQ-035 The bench SHALL drive a local read with addr=0x10 only -> mem_v_o=1, mem_addr_o=0x10, next cycle local_data_v_o=1 with data equal to memory content.
REQ-036 With starve_limit_p=4, the bench SHALL hold local_v_i=1 and remote_v_i=1 continuously -> remote_yumi_o=1 in cycle 5, local_stall_o=1 only in that cycle, FSM back to LOCAL_PRI.
REQ-037 The bench SHALL drive a remote write of 0xDEADBEEF with mask 4'b0011 while local is idle -> yumi the same cycle, mem_mask_o=0011, no data-valid pulse.
REQ-038 The bench SHALL drive alternating local and remote reads on consecutive cycles -> each valid returned to the correct requester one cycle later with no bubble.
REQ-039 The bench SHALL assert reset_i in REMOTE_FORCE with a read in flight -> no data valid follows and the state is LOCAL_PRI.
REQ-040 With VANILLA_DMEM_ARB_STATS_EN defined, the bench SHALL apply 10 conflict cycles -> conflict_count_o=10; with the macro undefined -> conflict_count_o=0.
